// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// MULT/MULTU/DIV/DIVU run for a fixed number of cycles while busy is high;
// MTHI/MTLO write HI/LO in a single cycle. flush aborts an in-flight op.
// Optional build macro MD_FAST_MUL_EN: multiplies complete on the accepting
// edge (busy never set for them); division timing is unchanged.
`timescale 1ns/1ps
module md_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Full-width product; sign-extending both operands to 2*WIDTH makes the
  // truncated unsigned product equal to the signed product.
  function automatic logic [2*WIDTH-1:0] mul_f(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             is_signed
  );
    logic [2*WIDTH-1:0] xe;
    logic [2*WIDTH-1:0] ye;
    xe = {{WIDTH{is_signed & x[WIDTH-1]}}, x};
    ye = {{WIDTH{is_signed & y[WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes and
  // then fixes signs: quotient truncates toward zero, remainder follows the
  // dividend. The most-negative / -1 case falls out naturally as
  // quotient = most-negative, remainder = 0.
  function automatic logic [2*WIDTH-1:0] div_f(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             is_signed
  );
    logic             neg_x;
    logic             neg_y;
    logic [WIDTH-1:0] mx;
    logic [WIDTH-1:0] my;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    neg_x = is_signed & x[WIDTH-1];
    neg_y = is_signed & y[WIDTH-1];
    mx    = neg_x ? (~x + WIDTH'(1)) : x;
    my    = neg_y ? (~y + WIDTH'(1)) : y;
    q     = mx / my;
    r     = mx % my;
    q     = (neg_x ^ neg_y) ? (~q + WIDTH'(1)) : q;
    r     = neg_x ? (~r + WIDTH'(1)) : r;
    return {r, q};
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_next_s;
  logic [2:0]       op_r;
  logic [2:0]       op_next_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] a_next_s;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] b_next_s;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] hi_next_s;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] lo_next_s;
  logic             done_r;
  logic             done_next_s;

  logic             accept_s;
  logic             op_r_is_mul_s;
  logic [2*WIDTH-1:0] mul_res_s;
  logic [2*WIDTH-1:0] div_res_s;

  assign accept_s      = start & ~flush & (op <= OP_MTLO);
  assign op_r_is_mul_s = (op_r == OP_MULT) || (op_r == OP_MULTU);
  assign mul_res_s     = mul_f(a_r, b_r, op_r == OP_MULT);
  assign div_res_s     = div_f(a_r, b_r, op_r == OP_DIV);

  // Next-state, operand latch, counter and HI/LO update logic.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    op_next_s    = op_r;
    a_next_s     = a_r;
    b_next_s     = b_r;
    hi_next_s    = hi_r;
    lo_next_s    = lo_r;
    done_next_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (op)
            OP_MTHI: hi_next_s = a;
            OP_MTLO: lo_next_s = a;
            OP_MULT, OP_MULTU: begin
`ifdef MD_FAST_MUL_EN
              {hi_next_s, lo_next_s} = mul_f(a, b, op == OP_MULT);
              done_next_s            = 1'b1;
`else
              op_next_s    = op;
              a_next_s     = a;
              b_next_s     = b;
              cnt_next_s   = CW'(MUL_LAT);
              state_next_s = ST_BUSY;
`endif
            end
            OP_DIV, OP_DIVU: begin
              op_next_s    = op;
              a_next_s     = a;
              b_next_s     = b;
              cnt_next_s   = CW'(DIV_LAT);
              state_next_s = ST_BUSY;
            end
            default: state_next_s = ST_IDLE;
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          // Abort: result discarded, no done pulse, even on the final edge.
          state_next_s = ST_IDLE;
          cnt_next_s   = '0;
        end else if (cnt_r == CW'(1)) begin
          state_next_s = ST_IDLE;
          cnt_next_s   = '0;
          done_next_s  = 1'b1;
          if (op_r_is_mul_s) begin
            {hi_next_s, lo_next_s} = mul_res_s;
          end else if (b_r != '0) begin
            {hi_next_s, lo_next_s} = div_res_s;
          end else begin
            // Divide by zero: HI/LO keep their previous values.
            hi_next_s = hi_r;
            lo_next_s = lo_r;
          end
        end else begin
          cnt_next_s = cnt_r - CW'(1);
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      op_r    <= 3'd0;
      a_r     <= '0;
      b_r     <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      op_r    <= op_next_s;
      a_r     <= a_next_s;
      b_r     <= b_next_s;
      hi_r    <= hi_next_s;
      lo_r    <= lo_next_s;
      done_r  <= done_next_s;
    end
  end

  assign busy = (state_r == ST_BUSY);
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage. Owns the HI/LO registers.
- Its hi/lo outputs feed the E/M pipeline register.
- Its busy output goes to the hazard logic, which stalls the pipeline and generates the clr pulses for the pipeline registers while an operation is in flight.
- Supports signed/unsigned MULT and DIV, plus single-cycle MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_LAT, 5, cycles busy for MULT/MULTU (minimum 1).
- DIV_LAT, 10, cycles busy for DIV/DIVU (minimum 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; op/a/b sampled on the edge where start=1 and the request is accepted.
- op  input  3  operation code: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7=no-op.
- a  input  WIDTH  operand rs (dividend / multiplicand / MTHI-MTLO data).
- b  input  WIDTH  operand rt (divisor / multiplier).
- flush  input  1  abort the in-flight operation (driven by hazard unit on branch/exception flush).
- busy  output  1  operation in flight; hazard unit stalls on any MFHI/MFLO/MD op while busy=1.
- done  output  1  one-cycle pulse when HI/LO have been updated by MULT/DIV.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous, active-high; clock clk): hi=0, lo=0, busy=0, done=0, internal counter=0, latched operands cleared. Reset wins over every other input, including mid-operation.
- Accept rule: a request is accepted on an edge with start=1, busy=0, flush=0 and op<=5.
  - start while busy=1 is ignored (no queueing).
  - op 6-7 is ignored.
- MTHI/MTLO: on the accepting edge, hi<=a (MTHI) or lo<=a (MTLO). busy stays 0 and done is not pulsed.
- MULT/DIV timing, with the accepting edge called E0:
  - a, b and op are latched at E0; the counter is loaded with LAT (MUL_LAT or DIV_LAT).
  - busy=1 from E0 to E_LAT; the counter decrements each edge.
  - At E_LAT: busy<=0, hi/lo<=result, done<=1 for exactly one cycle.
  - Total busy cycles = LAT. A new start is accepted at the earliest on E_LAT+1 (first edge with busy=0).
- MULT/MULTU arithmetic: 2*WIDTH-bit product of signed (MULT) or zero-extended (MULTU) operands; hi=upper WIDTH bits, lo=lower WIDTH bits.
- DIV/DIVU arithmetic:
  - lo=quotient, hi=remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Signed overflow (a=most negative, b=-1): lo=most negative value, hi=0.
- Divide by zero (b=0, DIV or DIVU): the operation still runs DIV_LAT cycles and done pulses, but hi/lo retain their previous values.
- Operand stability: results are computed from the operands latched at E0. Input changes during busy have no effect.
- Flush:
  - flush=1 while busy=1 aborts the operation: on that edge busy<=0, the counter clears, hi/lo are unchanged and no done pulse follows.
  - flush=1 together with start=1 while idle: flush wins and the request is dropped (this includes MTHI/MTLO).
  - flush on the same edge as E_LAT: flush wins, the result is discarded and done stays 0.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: MD_FAST_MUL_EN.
- Defined: MULT/MULTU complete in a single edge. hi/lo update on the accepting edge E0, done=1 the following cycle, and busy is never asserted for multiplies. Flush has no effect on an already-accepted multiply. MUL_LAT is unused.
- Undefined: multiplies follow the MUL_LAT multi-cycle timing above. DIV timing is unaffected either way.

Test Plan:
- Reset: reset=1 mid-DIV (2 cycles after start) -> next edge busy=0, hi=0, lo=0, done=0; no done pulse afterwards.
- MULT, a=0xFFFFFFFE (-2), b=3 -> busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done high for 1 cycle. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV, a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIVU with b=0 -> done pulses after 10 cycles, hi=0x11, lo=0x22.
- Flush/start interaction:
  - start MULT, flush on the 3rd busy cycle -> busy drops next edge, hi/lo unchanged, no done.
  - start asserted while busy -> ignored, and the original result is intact.
  - flush+MTHI on the same edge -> hi unchanged.
- MD_FAST_MUL_EN defined: MULT a=6, b=7 -> lo=42 on the accepting edge, busy never 1, done 1 cycle later.
